// File: rtl/mem_stage_pipelined.sv
// Memory stage: word-organised local RAM with byte/halfword lanes, alignment
// checking and a configurable number of wait states per aligned access.
module mem_stage_pipelined #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_Valid,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemoryWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        out_Stall,
    output logic        out_Valid,
    output logic [31:0] out_MemoryData,
    output logic        out_Misaligned
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [ADDR_BITS+1:0] addr;
        logic [31:0]          wdata;
        logic                 wr;
        logic [1:0]           size;
        logic                 sgn;
    } req_t;

    state_t               state;
    logic [2:0]           cnt;
    req_t                 r_req;
    req_t                 in_req;
    req_t                 acc;
    logic                 is_mem;
    logic                 in_mis;
    logic                 do_acc;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          rd_word;
    logic [31:0]          load_val;
    logic [31:0]          mem [0:(2**ADDR_BITS)-1];

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic s);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_ext = {{24{s & b[7]}}, b};
            2'b01:   load_ext = {{16{s & h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] a, input logic [1:0] sz);
        store_merge = w;
        case (sz)
            2'b00:   store_merge[{a, 3'b000} +: 8] = d[7:0];
            2'b01:   store_merge[{a[1], 4'b0000} +: 16] = d[15:0];
            default: store_merge = d;
        endcase
    endfunction

    always_comb begin
        in_req.addr  = ALUOut[ADDR_BITS+1:0];
        in_req.wdata = MemoryWriteData;
        in_req.wr    = MemWrite;
        in_req.size  = MemSize;
        in_req.sgn   = MemSigned;
    end

    assign is_mem = MemRead | MemWrite;
    assign in_mis = ((MemSize == 2'b01) & ALUOut[0]) | (MemSize[1] & (|ALUOut[1:0]));

    // With no wait states the access uses the live request at the capture
    // edge; otherwise it uses the captured copy at the edge leaving BUSY.
    assign acc      = (state == BUSY) ? r_req : in_req;
    assign do_acc   = !Reset &&
                      (((state == IDLE) && in_Valid && is_mem && !in_mis && (WS == 3'd0)) ||
                       ((state == BUSY) && (cnt == 3'd1)));
    assign idx      = acc.addr[ADDR_BITS+1:2];
    assign rd_word  = mem[idx];
    assign load_val = load_ext(rd_word, acc.addr[1:0], acc.size, acc.sgn);

    // Array contents survive reset on purpose.
    always_ff @(posedge Clk) begin
        if (do_acc && acc.wr)
            mem[idx] <= store_merge(rd_word, acc.wdata, acc.addr[1:0], acc.size);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            r_req          <= '0;
            out_Stall      <= 1'b0;
            out_Valid      <= 1'b0;
            out_MemoryData <= 32'd0;
            out_Misaligned <= 1'b0;
        end else begin
            out_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_Valid) begin
                        r_req <= in_req;
                        if (!is_mem) begin
                            out_Valid      <= 1'b1;
                            out_MemoryData <= ALUOut;
                            out_Misaligned <= 1'b0;
                        end else if (in_mis) begin
                            out_Valid      <= 1'b1;
                            out_MemoryData <= 32'd0;
                            out_Misaligned <= 1'b1;
                        end else if (WS == 3'd0) begin
                            out_Valid      <= 1'b1;
                            out_MemoryData <= MemWrite ? 32'd0 : load_val;
                            out_Misaligned <= 1'b0;
                        end else begin
                            state     <= BUSY;
                            cnt       <= WS;
                            out_Stall <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 3'd1) begin
                        state          <= IDLE;
                        cnt            <= 3'd0;
                        out_Stall      <= 1'b0;
                        out_Valid      <= 1'b1;
                        out_MemoryData <= r_req.wr ? 32'd0 : load_val;
                        out_Misaligned <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Bench: three instances (0, 1 and 3 wait states) share one request stream;
// a per-instance scoreboard checks result, misalignment flag, latency and stall time.
module tb_mem_stage_pipelined;

    logic              Clk;
    logic [2:0]        rst;
    logic              in_Valid;
    logic [31:0]       ALUOut;
    logic [31:0]       MemoryWriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [1:0]        MemSize;
    logic              MemSigned;
    logic [2:0]        st;
    logic [2:0]        ov;
    logic [2:0][31:0]  od;
    logic [2:0]        om;

    int ws[3] = '{0, 1, 3};
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cnt[3] = '{0, 0, 0};
    int exp_stall[3] = '{0, 0, 0};
    logic [31:0] hold_d[3] = '{32'd0, 32'd0, 32'd0};
    logic        hold_m[3] = '{1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] edata;
        logic        mis;
    } vec_t;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[25];

    mem_stage_pipelined #(.ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
        .Clk(Clk), .Reset(rst[0]), .in_Valid(in_Valid), .ALUOut(ALUOut),
        .MemoryWriteData(MemoryWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .out_Stall(st[0]), .out_Valid(ov[0]),
        .out_MemoryData(od[0]), .out_Misaligned(om[0]));

    mem_stage_pipelined #(.ADDR_BITS(8), .WAIT_STATES(1)) u_ws1 (
        .Clk(Clk), .Reset(rst[1]), .in_Valid(in_Valid), .ALUOut(ALUOut),
        .MemoryWriteData(MemoryWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .out_Stall(st[1]), .out_Valid(ov[1]),
        .out_MemoryData(od[1]), .out_Misaligned(om[1]));

    mem_stage_pipelined #(.ADDR_BITS(8), .WAIT_STATES(3)) u_ws3 (
        .Clk(Clk), .Reset(rst[2]), .in_Valid(in_Valid), .ALUOut(ALUOut),
        .MemoryWriteData(MemoryWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .out_Stall(st[2]), .out_Valid(ov[2]),
        .out_MemoryData(od[2]), .out_Misaligned(om[2]));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard: every out_Valid must match the oldest pending entry for that instance;
    // between pulses the outputs must hold the last result.
    always @(negedge Clk) begin
        int   idx;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (st[k]) stall_cnt[k]++;
            if (ov[k]) begin
                idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (idx < 0 && sb[i].dut == k) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_valid dut%0d: got data %h, required no pulse", k, od[k]);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    if (od[k] !== e.data || om[k] !== e.mis || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result dut%0d: got data %h mis %b cyc %0d, required %h %b cyc %0d",
                                 k, od[k], om[k], cyc, e.data, e.mis, e.cyc);
                    end
                    hold_d[k] = e.data;
                    hold_m[k] = e.mis;
                end
            end else begin
                checks++;
                if (od[k] !== hold_d[k] || om[k] !== hold_m[k]) begin
                    errors++;
                    $display("FAIL hold dut%0d: got %h %b, required %h %b",
                             k, od[k], om[k], hold_d[k], hold_m[k]);
                end
            end
        end
    end

    // Called at posedge+1; the request is captured at the next posedge.
    task automatic drive(input vec_t v, input logic [2:0] mask, input logic [2:0][31:0] ed);
        bit aligned;
        int lat;
        in_Valid        = 1'b1;
        ALUOut          = v.addr;
        MemoryWriteData = v.wdata;
        MemRead         = v.rd;
        MemWrite        = v.wr;
        MemSize         = v.size;
        MemSigned       = v.sgn;
        aligned = (v.rd | v.wr) && !v.mis;
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                lat = aligned ? ws[k] + 1 : 1;
                sb.push_back('{k, ed[k], v.mis, cyc + lat});
                exp_stall[k] += aligned ? ws[k] : 0;
            end
        end
        @(posedge Clk);
        #1;
        in_Valid        = 1'b0;
        ALUOut          = $urandom;
        MemoryWriteData = $urandom;
        MemRead         = 1'($urandom);
        MemWrite        = 1'($urandom);
        MemSize         = 2'($urandom);
        MemSigned       = 1'($urandom);
    endtask

    task automatic wait_done(input bit chk_stall);
        for (int t = 0; t < 40 && sb.size() != 0; t++) begin
            @(posedge Clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge Clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (chk_stall) begin
                checks++;
                if (stall_cnt[k] != exp_stall[k]) begin
                    errors++;
                    $display("FAIL stall_cycles dut%0d: got %0d, required %0d", k, stall_cnt[k], exp_stall[k]);
                end
            end
            stall_cnt[k] = 0;
            exp_stall[k] = 0;
        end
    endtask

    task automatic check_zero(input int k, input string name);
        checks++;
        if (st[k] !== 1'b0 || ov[k] !== 1'b0 || od[k] !== 32'd0 || om[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d: got stall %b valid %b data %h mis %b, required all zero",
                     name, k, st[k], ov[k], od[k], om[k]);
        end
    endtask

    initial begin
        vec_t v;
        tbl = '{
            //  addr          wdata         rd    wr    size   sgn   expected      mis
            '{32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0010, 32'h0,         1'b1, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0},
            '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0013, 32'hAAAA_AA80, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0013, 32'h0,         1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0},
            '{32'h0000_0013, 32'h0,         1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0080, 1'b0},
            '{32'h0000_0010, 32'h0,         1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0000, 1'b0},
            '{32'h0000_0011, 32'h0,         1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h0000_0010, 32'h0,         1'b1, 1'b0, 2'b11, 1'b0, 32'h8000_0000, 1'b0},
            '{32'h0000_0012, 32'h1234_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0012, 32'h0,         1'b1, 1'b0, 2'b01, 1'b1, 32'hFFFF_BEEF, 1'b0},
            '{32'h0000_0010, 32'h0,         1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0400, 32'h1234_5678, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0000, 32'h0,         1'b1, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 1'b0},
            '{32'hCAFE_F00D, 32'h0BAD_0BAD, 1'b0, 1'b0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0},
            '{32'h0000_0020, 32'h55AA_55AA, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0020, 32'h0,         1'b1, 1'b0, 2'b10, 1'b0, 32'h55AA_55AA, 1'b0},
            '{32'h0000_0021, 32'h0,         1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0055, 1'b0},
            '{32'h0000_0022, 32'h0,         1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFF_FFAA, 1'b0},
            '{32'h0000_0022, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h0000_0023, 32'h0000_FFFF, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h0000_0020, 32'h0,         1'b1, 1'b0, 2'b10, 1'b0, 32'h55AA_55AA, 1'b0},
            '{32'h0000_1021, 32'h0000_0011, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0020, 32'h0,         1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_11AA, 1'b0},
            '{32'h0000_0020, 32'h0,         1'b1, 1'b0, 2'b10, 1'b0, 32'h55AA_11AA, 1'b0}
        };

        rst             = 3'b111;
        in_Valid        = 1'b0;
        ALUOut          = 32'd0;
        MemoryWriteData = 32'd0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        MemSize         = 2'b00;
        MemSigned       = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        for (int k = 0; k < 3; k++) check_zero(k, "reset_state");
        rst = 3'b000;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i], 3'b111, {tbl[i].edata, tbl[i].edata, tbl[i].edata});
            wait_done(1'b1);
        end

        // Requests while BUSY are dropped; a request on the out_Valid cycle is taken.
        v = '{32'h0000_0010, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hBEEF_0000, 1'b0};
        drive(v, 3'b111, {3{v.edata}});
        v = '{32'h0000_0077, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0077, 1'b0};
        drive(v, 3'b001, {3{v.edata}});
        v = '{32'h0000_00C3, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_00C3, 1'b0};
        drive(v, 3'b011, {3{v.edata}});
        wait_done(1'b1);

        // Reset in the second BUSY cycle of the 3-wait-state instance aborts its store.
        v = '{32'h0000_0020, 32'h1111_1111, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
        drive(v, 3'b011, {3{v.edata}});
        @(posedge Clk);
        #1;
        checks++;
        if (st[2] !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset dut2: got stall %b, required 1", st[2]);
        end
        rst[2]    = 1'b1;
        hold_d[2] = 32'd0;
        hold_m[2] = 1'b0;
        #1;
        check_zero(2, "reset_in_busy");
        @(posedge Clk);
        #1;
        rst[2] = 1'b0;
        v = '{32'h0000_0020, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0};
        drive(v, 3'b111, {32'h55AA_11AA, 32'h1111_1111, 32'h1111_1111});
        wait_done(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
